// File: rtl/t01_vga_fb_arbiter.sv
// Framebuffer arbiter: 160x120x3 SRAM shared by VGA display reads (priority) and two round-robin writers.
// Optional T01_FB_WRITE_GUARD_EN drops out-of-range writes and raises a sticky wr_err.
module t01_vga_fb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de,
    input  logic [9:0]  x_in,
    input  logic [9:0]  y_in,
    output logic [2:0]  color_out,
    input  logic        req_a,
    input  logic [14:0] addr_a,
    input  logic [2:0]  data_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [14:0] addr_b,
    input  logic [2:0]  data_b,
    output logic        ack_b,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_wdata,
    input  logic [2:0]  mem_rdata,
    output logic        wr_err
);

    localparam logic [14:0] FB_SIZE  = 15'd19200;
    localparam logic [7:0]  LAST_COL = 8'd159;
    localparam logic [9:0]  LAST_Y   = 10'd479;

    typedef enum logic [1:0] {BLANK, ACTIVE, PRELOAD} state_t;

    state_t      state_q;
    state_t      state_cur;
    logic [9:0]  y_last_p1;
    logic        rd_vld_p1;
    logic        last_b;
    logic        disp_rd;
    logic [14:0] rd_addr;
    logic [9:0]  y_nxt;
    logic [7:0]  col_nxt;
    logic        grant_a;
    logic        grant_b;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;

    function automatic logic [14:0] fb_addr(input logic [7:0] row, input logic [7:0] col);
        return ({7'd0, row} << 7) + ({7'd0, row} << 5) + {7'd0, col};
    endfunction

    // state_cur is the state of the present cycle, so PRELOAD coincides with the first de=0 cycle
    always_comb begin
        state_cur = state_q;
        case (state_q)
            BLANK:   if (de) state_cur = ACTIVE;
            ACTIVE:  if (!de) state_cur = PRELOAD;
            PRELOAD: state_cur = BLANK;
            default: state_cur = BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_cur;
        end
    end

    // stage p0: display read address, one framebuffer pixel ahead of the beam
    always_comb begin
        col_nxt = (x_in[9:2] >= LAST_COL) ? 8'd0 : x_in[9:2] + 8'd1;
        y_nxt   = (y_last_p1 == LAST_Y) ? 10'd0 : y_last_p1 + 10'd1;
        disp_rd = 1'b0;
        rd_addr = '0;
        if (state_cur == ACTIVE && x_in[1:0] == 2'b10) begin
            disp_rd = rst_n;
            rd_addr = fb_addr(y_in[9:2], col_nxt);
        end else if (state_cur == PRELOAD) begin
            disp_rd = rst_n;
            rd_addr = fb_addr(y_nxt[9:2], 8'd0);
        end
    end

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_rd) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (rst_n) begin
            if (req_a && (!req_b || last_b)) begin
                grant_a = 1'b1;
            end else if (req_b) begin
                grant_b = 1'b1;
            end
        end
        wr_addr = grant_a ? addr_a : addr_b;
        wr_data = grant_a ? data_a : data_b;
        if (grant_a || grant_b) begin
`ifdef T01_FB_WRITE_GUARD_EN
            if (wr_addr < FB_SIZE) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
            end
`else
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
`endif
        end
    end

    assign ack_a = grant_a;
    assign ack_b = grant_b;

    // stage p1: read data returns one cycle after the display read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1 <= 1'b0;
            color_out <= '0;
            last_b    <= 1'b1;
        end else begin
            rd_vld_p1 <= disp_rd;
            if (rd_vld_p1) color_out <= mem_rdata;
            if (grant_a) begin
                last_b <= 1'b0;
            end else if (grant_b) begin
                last_b <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_cur == ACTIVE) y_last_p1 <= y_in;
    end

`ifdef T01_FB_WRITE_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else if ((grant_a || grant_b) && wr_addr >= FB_SIZE) begin
            wr_err <= 1'b1;
        end
    end
`else
    assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_t01_vga_fb_arbiter.sv
// Scoreboard bench for t01_vga_fb_arbiter: expected bus cycles and colour changes are queued by
// the stimulus and consumed by independent monitors on the falling clock edge.
module tb_t01_vga_fb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        de;
    logic [9:0]  x_in;
    logic [9:0]  y_in;
    logic [2:0]  color_out;
    logic        req_a;
    logic [14:0] addr_a;
    logic [2:0]  data_a;
    logic        ack_a;
    logic        req_b;
    logic [14:0] addr_b;
    logic [2:0]  data_b;
    logic        ack_b;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;
    logic        wr_err;

    t01_vga_fb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .de(de), .x_in(x_in), .y_in(y_in), .color_out(color_out),
        .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wr_err(wr_err)
    );

    typedef struct packed {
        logic        en;
        logic        we;
        logic [14:0] addr;
        logic [2:0]  wd;
        logic        aa;
        logic        ab;
    } bus_t;

    bus_t       bus_q[$];
    logic [2:0] col_q[$];
    logic [2:0] fb [0:19199];
    logic [2:0] last_col = 3'd0;
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only SRAM model with one cycle of latency
    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= fb[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic bus_t mk(input logic en, input logic we, input logic [14:0] a,
                                input logic [2:0] d, input logic aa, input logic ab);
        bus_t b;
        b.en = en; b.we = we; b.addr = a; b.wd = d; b.aa = aa; b.ab = ab;
        return b;
    endfunction

    always @(negedge clk) begin : mon_bus
        bus_t act;
        if (mem_en === 1'b1 || ack_a === 1'b1 || ack_b === 1'b1) begin
            act = {mem_en, mem_we, mem_addr, mem_wdata, ack_a, ack_b};
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: got %h required no access", act);
            end else begin
                check("bus", 32'(act), 32'(bus_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin : mon_col
        if (color_out !== last_col) begin
            if (col_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL color_unexpected: got %0d required no change from %0d", color_out, last_col);
            end else begin
                check("color", 32'(color_out), 32'(col_q.pop_front()));
            end
            last_col = color_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        de   = 1'b1;
        x_in = x[9:0];
        y_in = y[9:0];
        tick();
    endtask

    initial begin
        rst_n = 1'b0; de = 1'b0; x_in = '0; y_in = '0;
        req_a = 1'b1; addr_a = 15'd100; data_a = 3'd1;
        req_b = 1'b1; addr_b = 15'd200; data_b = 3'd2;
        for (int i = 0; i < 19200; i++) fb[i] = 3'd0;
        fb[160] = 3'd7; fb[161] = 3'd3; fb[162] = 3'd5; fb[163] = 3'd2;
        fb[19040] = 3'd1; fb[0] = 3'd6; fb[321] = 3'd4; fb[322] = 3'd3;

        // Reset holds everything quiet even with both writers requesting
        tick(); tick();
        check("rst_ack_a", 32'(ack_a), 32'd0);
        check("rst_ack_b", 32'(ack_b), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_color", 32'(color_out), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);

        // Blanking arbitration: A first, then alternate; single requesters; last-grant tracking
        bus_q.push_back(mk(1, 1, 15'd100, 3'd1, 1, 0));
        bus_q.push_back(mk(1, 1, 15'd200, 3'd2, 0, 1));
        bus_q.push_back(mk(1, 1, 15'd100, 3'd1, 1, 0));
        bus_q.push_back(mk(1, 1, 15'd200, 3'd2, 0, 1));
        rst_n = 1'b1;
        repeat (4) tick();
        req_a = 1'b0;
        bus_q.push_back(mk(1, 1, 15'd200, 3'd2, 0, 1));
        tick();
        req_a = 1'b1;
        bus_q.push_back(mk(1, 1, 15'd100, 3'd1, 1, 0));
        tick();
        req_b = 1'b0;
        bus_q.push_back(mk(1, 1, 15'd100, 3'd1, 1, 0));
        tick();
        req_b = 1'b1;
        bus_q.push_back(mk(1, 1, 15'd200, 3'd2, 0, 1));
        tick();
        req_a = 1'b0; req_b = 1'b0;
        tick();

        // Line y=4: reads at x=2,6,10; writer A stalled by the x=6 read; PRELOAD uses latched y
        bus_q.push_back(mk(1, 0, 15'd161, 3'd0, 0, 0));
        bus_q.push_back(mk(1, 0, 15'd162, 3'd0, 0, 0));
        bus_q.push_back(mk(1, 1, 15'd300, 3'd4, 1, 0));
        bus_q.push_back(mk(1, 0, 15'd163, 3'd0, 0, 0));
        bus_q.push_back(mk(1, 0, 15'd160, 3'd0, 0, 0));
        col_q.push_back(3'd3); col_q.push_back(3'd5); col_q.push_back(3'd2); col_q.push_back(3'd7);
        for (int x = 0; x < 12; x++) begin
            if (x == 6) begin req_a = 1'b1; addr_a = 15'd300; data_a = 3'd4; end
            if (x == 8) req_a = 1'b0;
            pix(x, 4);
        end
        de = 1'b0; y_in = 10'd7; x_in = '0;
        repeat (4) tick();

        // Last line y=479: column wrap at x=638, PRELOAD wraps to row 0, writer B waits out PRELOAD
        bus_q.push_back(mk(1, 0, 15'd19040, 3'd0, 0, 0));
        bus_q.push_back(mk(1, 0, 15'd0, 3'd0, 0, 0));
        bus_q.push_back(mk(1, 1, 15'd500, 3'd3, 0, 1));
        col_q.push_back(3'd1); col_q.push_back(3'd6);
        for (int x = 636; x < 640; x++) pix(x, 479);
        de = 1'b0; y_in = 10'd0; x_in = '0;
        req_b = 1'b1; addr_b = 15'd500; data_b = 3'd3;
        tick();
        tick();
        req_b = 1'b0;
        tick(); tick();

        // Out-of-range write
        req_b = 1'b1; addr_b = 15'd19200; data_b = 3'd5;
`ifdef T01_FB_WRITE_GUARD_EN
        bus_q.push_back(mk(0, 0, 15'd0, 3'd0, 0, 1));
`else
        bus_q.push_back(mk(1, 1, 15'd19200, 3'd5, 0, 1));
`endif
        tick();
        req_b = 1'b0;
        tick();
`ifdef T01_FB_WRITE_GUARD_EN
        check("wr_err_set", 32'(wr_err), 32'd1);
        tick();
        check("wr_err_sticky", 32'(wr_err), 32'd1);
`else
        check("wr_err_tied", 32'(wr_err), 32'd0);
        tick();
        check("wr_err_still", 32'(wr_err), 32'd0);
`endif
        req_a = 1'b1; addr_a = 15'd50; data_a = 3'd1;
        bus_q.push_back(mk(1, 1, 15'd50, 3'd1, 1, 0));
        tick();
        req_a = 1'b0;
        tick();

        // Reset mid-line with a read in flight; afterwards A must win again
        bus_q.push_back(mk(1, 0, 15'd321, 3'd0, 0, 0));
        bus_q.push_back(mk(1, 0, 15'd322, 3'd0, 0, 0));
        col_q.push_back(3'd4); col_q.push_back(3'd0);
        for (int x = 0; x < 7; x++) pix(x, 8);
        rst_n = 1'b0; de = 1'b0; x_in = '0;
        req_a = 1'b1; addr_a = 15'd100; data_a = 3'd1;
        req_b = 1'b1; addr_b = 15'd200; data_b = 3'd2;
        tick();
        check("mid_rst_color", 32'(color_out), 32'd0);
        check("mid_rst_ack_a", 32'(ack_a), 32'd0);
        check("mid_rst_wr_err", 32'(wr_err), 32'd0);
        tick();
        bus_q.push_back(mk(1, 1, 15'd100, 3'd1, 1, 0));
        bus_q.push_back(mk(1, 1, 15'd200, 3'd2, 0, 1));
        rst_n = 1'b1;
        tick(); tick();
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();

        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check("col_q_drained", 32'(col_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
